// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS control sequencer.
// The PERF_CNT_EN macro is consumed by mc_sequencer. This package has no configuration of its own.
package mc_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned PC_SRC_W = 2;
   localparam int unsigned STATE_W  = 3;
   localparam int unsigned CLS_W    = 8;

   typedef enum logic [STATE_W-1:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5,
      FAULT  = 3'd6
   } state_t;

   localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ = 2'd0;
   localparam logic [PC_SRC_W-1:0] PC_SRC_BR  = 2'd1;
   localparam logic [PC_SRC_W-1:0] PC_SRC_JMP = 2'd2;
   localparam logic [PC_SRC_W-1:0] PC_SRC_RS  = 2'd3;

   localparam logic [OP_W-1:0] OP_RTYPE   = 6'd0;
   localparam logic [OP_W-1:0] OP_J       = 6'd2;
   localparam logic [OP_W-1:0] OP_JAL     = 6'd3;
   localparam logic [OP_W-1:0] OP_BEQ     = 6'd4;
   localparam logic [OP_W-1:0] OP_BNE     = 6'd5;
   localparam logic [OP_W-1:0] OP_BGTZ    = 6'd7;
   localparam logic [OP_W-1:0] OP_LW      = 6'd35;
   localparam logic [OP_W-1:0] OP_SH      = 6'd41;
   localparam logic [OP_W-1:0] OP_SW      = 6'd43;
   localparam logic [OP_W-1:0] FN_JR      = 6'd8;
   localparam logic [OP_W-1:0] FN_SYSCALL = 6'd12;

   // One-hot instruction class; all-zero means unknown opcode (executes as NOP)
   typedef struct packed {
      logic alu;
      logic load;
      logic store;
      logic branch;
      logic jump;
      logic jal;
      logic jr;
      logic syscall;
   } instr_class_t;

   function automatic logic [PC_SRC_W-1:0] pc_src_of(input instr_class_t c);
      if (c.jr)              return PC_SRC_RS;
      if (c.jump || c.jal)   return PC_SRC_JMP;
      if (c.branch)          return PC_SRC_BR;
      return PC_SRC_SEQ;
   endfunction

endpackage

// File: rtl/mc_instr_class.sv
// Combinational op/func classifier feeding the sequencer FSM with a one-hot class.
module mc_instr_class
   import mc_pkg::*;
(
   input  logic [OP_W-1:0]  op,
   input  logic [OP_W-1:0]  func,
   output logic [CLS_W-1:0] cls
);

   instr_class_t c;

   always_comb begin
      c = '0;
      if (op == OP_RTYPE) begin
         if (func == FN_SYSCALL)  c.syscall = 1'b1;
         else if (func == FN_JR)  c.jr      = 1'b1;
         else                     c.alu     = 1'b1;
      end else if (op[5:3] == 3'b001) begin
         // ADDI..LUI share the 001xxx opcode group
         c.alu = 1'b1;
      end else begin
         case (op)
            OP_J:                    c.jump   = 1'b1;
            OP_JAL:                  c.jal    = 1'b1;
            OP_BEQ, OP_BNE, OP_BGTZ: c.branch = 1'b1;
            OP_LW:                   c.load   = 1'b1;
            OP_SH, OP_SW:            c.store  = 1'b1;
            default:                 c        = '0;
         endcase
      end
   end

   assign cls = c;

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM for the MIPS core.
// Optional PERF_CNT_EN adds cycle_cnt/instr_cnt performance counter outputs.
module mc_sequencer
   import mc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OP_W-1:0]     op,
   input  logic [OP_W-1:0]     func,
   input  logic                br_taken,
   input  logic                mem_ready,
   input  logic                resume,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                ir_we,
   output logic                pc_we,
   output logic [PC_SRC_W-1:0] pc_src,
   output logic                reg_we,
   output logic [STATE_W-1:0]  state,
   output logic                halted,
`ifdef PERF_CNT_EN
   output logic                fault,
   output logic [31:0]         cycle_cnt,
   output logic [31:0]         instr_cnt
`else
   output logic                fault
`endif
);

   state_t                cur_state;
   state_t                nxt_state;
   logic [TO_W-1:0]       wait_cnt;
   logic [TO_W-1:0]       wait_nxt;
   logic [CLS_W-1:0]      cls_bits;
   instr_class_t          cls;
   logic                  access;
   logic                  timeout_hit;
   logic                  rd_nxt;
   logic                  wr_nxt;
   logic [PC_SRC_W-1:0]   pc_src_nxt;

   mc_instr_class u_class (
      .op   (op),
      .func (func),
      .cls  (cls_bits)
   );

   assign cls         = instr_class_t'(cls_bits);
   // A memory cycle only counts once its strobe is actually on the bus
   assign access      = mem_rd | mem_wr;
   assign timeout_hit = (wait_cnt == TO_W'(MEM_TIMEOUT - 1));

   // Next state, wait counter and per-cycle enables
   always_comb begin
      nxt_state  = cur_state;
      wait_nxt   = wait_cnt;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      rd_nxt     = 1'b0;
      wr_nxt     = 1'b0;
      pc_src_nxt = PC_SRC_SEQ;

      unique case (cur_state)
         FETCH: begin
            if (access) begin
               if (mem_ready) begin
                  ir_we     = 1'b1;
                  pc_we     = 1'b1;
                  nxt_state = DECODE;
               end else if (timeout_hit) begin
                  nxt_state = FAULT;
               end else begin
                  wait_nxt  = wait_cnt + TO_W'(1);
               end
            end
         end
         DECODE: nxt_state = cls.syscall ? HALT : EXEC;
         EXEC: begin
            nxt_state = FETCH;
            if (cls.jump || cls.jal || cls.jr) pc_we = 1'b1;
            if (cls.branch)                    pc_we = br_taken;
            if (cls.jal)                       reg_we = 1'b1;
            if (cls.load || cls.store)         nxt_state = MEM;
            else if (cls.alu)                  nxt_state = WB;
         end
         MEM: begin
            if (access) begin
               if (mem_ready) begin
                  nxt_state = cls.load ? WB : FETCH;
               end else if (timeout_hit) begin
                  nxt_state = FAULT;
               end else begin
                  wait_nxt  = wait_cnt + TO_W'(1);
               end
            end
         end
         WB: begin
            reg_we    = 1'b1;
            nxt_state = FETCH;
         end
         HALT:    if (resume) nxt_state = FETCH;
         FAULT:   nxt_state = FAULT;
         default: nxt_state = FAULT;
      endcase

      if (nxt_state != cur_state) wait_nxt = '0;

      // Moore outputs are precomputed from the next state so they come straight from flops
      rd_nxt = (nxt_state == FETCH) || ((nxt_state == MEM) && cls.load);
      wr_nxt = (nxt_state == MEM) && cls.store;
      if (nxt_state == EXEC) pc_src_nxt = pc_src_of(cls);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_state <= FETCH;
         wait_cnt  <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         pc_src    <= PC_SRC_SEQ;
         halted    <= 1'b0;
         fault     <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         wait_cnt  <= wait_nxt;
         mem_rd    <= rd_nxt;
         mem_wr    <= wr_nxt;
         pc_src    <= pc_src_nxt;
         halted    <= (nxt_state == HALT);
         fault     <= (nxt_state == FAULT);
      end
   end

   assign state = cur_state;

`ifdef PERF_CNT_EN
   // Active-cycle and decoded-instruction counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if ((cur_state != HALT) && (cur_state != FAULT)) cycle_cnt <= cycle_cnt + 32'd1;
         if (cur_state == DECODE)                         instr_cnt <= instr_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: queue-based per-instruction cycle model.
module tb_mc_sequencer;

   localparam int unsigned TIMEOUT = 255;
   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                          S_WB = 3'd4, S_HALT = 3'd5, S_FAULT = 3'd6;

   typedef enum {K_ALU, K_LOAD, K_STORE, K_BR, K_J, K_JAL, K_JR, K_SYS, K_NOP} kind_t;

   typedef struct packed {
      logic [2:0] st;
      logic       rd, wr, ir, pcw;
      logic [1:0] pcs;
      logic       rw, hlt, flt;
   } obs_t;

   typedef struct {
      obs_t       e;
      logic       rdy, rsm, br, ld;
      logic [5:0] op, fn;
   } step_t;

   logic       clk = 1'b0;
   logic       rst_n, br_taken, mem_ready, resume;
   logic [5:0] op, func;
   logic       mem_rd, mem_wr, ir_we, pc_we, reg_we, halted, fault;
   logic [1:0] pc_src;
   logic [2:0] state;
`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
   int unsigned m_cycles, m_instrs;
`endif

   int    checks = 0;
   int    failures = 0;
   step_t q[$];
   obs_t  o;
   bit    flt;

   always #5 clk = ~clk;

   mc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func(func), .br_taken(br_taken),
      .mem_ready(mem_ready), .resume(resume), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
      .state(state), .halted(halted),
`ifdef PERF_CNT_EN
      .fault(fault), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`else
      .fault(fault)
`endif
   );

   assign o = {state, mem_rd, mem_wr, ir_we, pc_we, pc_src, reg_we, halted, fault};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic obs_t mk(input logic [2:0] st, input logic rd, input logic wr,
                               input logic ir, input logic pcw, input logic [1:0] pcs,
                               input logic rw);
      obs_t r;
      r.st = st; r.rd = rd; r.wr = wr; r.ir = ir; r.pcw = pcw; r.pcs = pcs; r.rw = rw;
      r.hlt = (st == S_HALT);
      r.flt = (st == S_FAULT);
      return r;
   endfunction

   function automatic kind_t kind_of(input logic [5:0] iop, input logic [5:0] ifn);
      if (iop == 6'd0) return (ifn == 6'd12) ? K_SYS : (ifn == 6'd8) ? K_JR : K_ALU;
      if (iop >= 6'd8 && iop <= 6'd15) return K_ALU;
      case (iop)
         6'd2:               return K_J;
         6'd3:               return K_JAL;
         6'd4, 6'd5, 6'd7:   return K_BR;
         6'd35:              return K_LOAD;
         6'd41, 6'd43:       return K_STORE;
         default:            return K_NOP;
      endcase
   endfunction

   task automatic push(input obs_t e, input logic rdy, input logic rsm, input logic br,
                       input logic ld, input logic [5:0] iop, input logic [5:0] ifn);
      step_t s;
      s.e = e; s.rdy = rdy; s.rsm = rsm; s.br = br; s.ld = ld; s.op = iop; s.fn = ifn;
      q.push_back(s);
   endtask

   // A memory access with 'waits' not-ready cycles; at or beyond the limit it ends in FAULT
   task automatic add_access(input logic [2:0] st, input logic rd, input logic wr, input int waits,
                             input obs_t done, input logic ld, input logic [5:0] iop,
                             input logic [5:0] ifn, output bit faulted);
      int n = (waits >= int'(TIMEOUT)) ? int'(TIMEOUT) : waits;
      faulted = (waits >= int'(TIMEOUT));
      for (int i = 0; i < n; i++) push(mk(st, rd, wr, 0, 0, 2'd0, 0), 1'b0, rb(), rb(), 1'b0, iop, ifn);
      if (faulted) begin
         for (int i = 0; i < 6; i++) push(mk(S_FAULT, 0, 0, 0, 0, 2'd0, 0), rb(), rb(), rb(), 1'b0, iop, ifn);
      end else begin
         push(done, 1'b1, rb(), rb(), ld, iop, ifn);
      end
   endtask

   task automatic plan_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic br,
                             input int fw, input int mw, input int hn, output bit faulted);
      kind_t      k = kind_of(iop, ifn);
      logic       pcw;
      logic [1:0] pcs;
      add_access(S_FETCH, 1'b1, 1'b0, fw, mk(S_FETCH, 1, 0, 1, 1, 2'd0, 0), 1'b1, iop, ifn, faulted);
      if (faulted) return;
      push(mk(S_DECODE, 0, 0, 0, 0, 2'd0, 0), rb(), rb(), rb(), 1'b0, iop, ifn);
      if (k == K_SYS) begin
         for (int i = 0; i < hn; i++) push(mk(S_HALT, 0, 0, 0, 0, 2'd0, 0), rb(), 1'b0, rb(), 1'b0, iop, ifn);
         push(mk(S_HALT, 0, 0, 0, 0, 2'd0, 0), rb(), 1'b1, rb(), 1'b0, iop, ifn);
         return;
      end
      pcw = (k == K_J || k == K_JAL || k == K_JR) ? 1'b1 : (k == K_BR) ? br : 1'b0;
      pcs = (k == K_J || k == K_JAL) ? 2'd2 : (k == K_JR) ? 2'd3 : (k == K_BR) ? 2'd1 : 2'd0;
      push(mk(S_EXEC, 0, 0, 0, pcw, pcs, k == K_JAL), rb(), rb(), br, 1'b0, iop, ifn);
      if (k == K_LOAD || k == K_STORE) begin
         add_access(S_MEM, k == K_LOAD, k == K_STORE, mw,
                    mk(S_MEM, k == K_LOAD, k == K_STORE, 0, 0, 2'd0, 0), 1'b0, iop, ifn, faulted);
         if (faulted) return;
      end
      if (k == K_ALU || k == K_LOAD) push(mk(S_WB, 0, 0, 0, 0, 2'd0, 1), rb(), rb(), rb(), 1'b0, iop, ifn);
   endtask

   task automatic run_q();
      step_t s;
      int    n = 0;
      while (q.size() > 0) begin
         s = q.pop_front();
         mem_ready = s.rdy; resume = s.rsm; br_taken = s.br;
         @(negedge clk);
         chk($sformatf("cycle%0d_op%0d", n, s.op), 32'(o), 32'(s.e));
`ifdef PERF_CNT_EN
         chk("cycle_cnt", cycle_cnt, m_cycles);
         chk("instr_cnt", instr_cnt, m_instrs);
`endif
         @(posedge clk); #1;
`ifdef PERF_CNT_EN
         if (s.e.st != S_HALT && s.e.st != S_FAULT) m_cycles++;
         if (s.e.st == S_DECODE) m_instrs++;
`endif
         if (s.ld) begin op = s.op; func = s.fn; end
         n++;
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0; mem_ready = rb(); resume = rb(); br_taken = rb();
      @(posedge clk); #1;
      @(negedge clk);
      chk(tag, 32'(o), 32'(mk(S_FETCH, 0, 0, 0, 0, 2'd0, 0)));
`ifdef PERF_CNT_EN
      chk({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
      chk({tag, "_instr_cnt"}, instr_cnt, 32'd0);
`endif
      rst_n = 1'b1; mem_ready = 1'b0; resume = 1'b0;
      @(posedge clk); #1;
`ifdef PERF_CNT_EN
      m_cycles = 1; m_instrs = 0;
`endif
   endtask

   task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic br,
                            input int fw, input int mw, input int hn);
      plan_instr(iop, ifn, br, fw, mw, hn, flt);
      run_q();
      if (flt) do_reset("reset_after_fault");
   endtask

   logic [5:0] op_tab [14] = '{6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7, 6'd35,
                                6'd41, 6'd43, 6'd9, 6'd13, 6'd6, 6'd63};
   logic [5:0] fn_tab [5]  = '{6'd32, 6'd34, 6'd37, 6'd8, 6'd12};

   initial begin
      rst_n = 1'b0; op = 6'd0; func = 6'd32; br_taken = 1'b0; mem_ready = 1'b0; resume = 1'b0;
      do_reset("reset");

      run_instr(6'd0, 6'd32, 1'b0, 0, 0, 0);   // ADD, no waits
      run_instr(6'd35, 6'd0, 1'b0, 0, 3, 0);   // LW, 3 wait states in MEM
      run_instr(6'd4, 6'd0, 1'b1, 1, 0, 0);    // BEQ taken
      run_instr(6'd4, 6'd0, 1'b0, 0, 0, 0);    // BEQ not taken
      run_instr(6'd0, 6'd12, 1'b0, 0, 0, 10);  // SYSCALL, 10 halted cycles then resume
      run_instr(6'd2, 6'd0, 1'b0, 2, 0, 0);    // J
      run_instr(6'd3, 6'd0, 1'b0, 0, 0, 0);    // JAL
      run_instr(6'd0, 6'd8, 1'b0, 0, 0, 0);    // JR
      run_instr(6'd5, 6'd0, 1'b1, 0, 0, 0);    // BNE
      run_instr(6'd7, 6'd0, 1'b1, 0, 0, 0);    // BGTZ
      run_instr(6'd43, 6'd0, 1'b0, 0, 2, 0);   // SW
      run_instr(6'd41, 6'd0, 1'b0, 1, 0, 0);   // SH
      run_instr(6'd8, 6'd0, 1'b0, 0, 0, 0);    // ADDI
      run_instr(6'd6, 6'd0, 1'b1, 0, 0, 0);    // unknown opcode: NOP

      for (int i = 0; i < 60; i++) begin
         logic [5:0] rop, rfn;
         rop = op_tab[$urandom_range(0, 13)];
         rfn = fn_tab[$urandom_range(0, 4)];
         run_instr(rop, rfn, rb(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 5)));
      end

      run_instr(6'd0, 6'd32, 1'b0, int'(TIMEOUT) - 1, 0, 0);  // ready in last allowed fetch cycle
      run_instr(6'd0, 6'd32, 1'b0, int'(TIMEOUT), 0, 0);      // fetch timeout -> FAULT, then reset
      run_instr(6'd35, 6'd0, 1'b0, 0, int'(TIMEOUT) - 1, 0);  // ready in last allowed MEM cycle
      run_instr(6'd35, 6'd0, 1'b0, 0, int'(TIMEOUT), 0);      // MEM timeout -> FAULT, then reset

      // Reset during a stalled SW in MEM: strobe must drop and no write commits
      plan_instr(6'd43, 6'd0, 1'b0, 0, 50, 0, flt);
      while (q.size() > 6) void'(q.pop_back());
      run_q();
      do_reset("reset_mid_sw");
      run_instr(6'd0, 6'd32, 1'b0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
